// File: rtl/enemy_ai_pkg.sv
// Shared types and defaults for the enemy AI controller.
package enemy_ai_pkg;

  localparam int unsigned X_W   = 11;
  localparam int unsigned DX_W  = 12;
  localparam int unsigned CNT_W = 8;

  localparam int unsigned AI_NEAR_DIST     = 48;
  localparam int unsigned AI_REACT_FRAMES  = 3;
  localparam int unsigned AI_DEFEND_FRAMES = 8;
  localparam int unsigned AI_ATK_COOLDOWN  = 12;
  localparam logic [15:0] AI_LFSR_SEED     = 16'hACE1;
  localparam logic [15:0] AI_LFSR_MASK     = 16'hB400;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    AI_IDLE     = 3'd0,
    AI_APPROACH = 3'd1,
    AI_RETREAT  = 3'd2,
    AI_GUARD    = 3'd3,
    AI_ATTACK   = 3'd4
  } ai_state_e;

  typedef struct packed {
    logic right;
    logic left;
    logic jump;
    logic squat;
    logic defend;
    logic attack;
  } ai_cmd_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ AI_LFSR_MASK) : (q >> 1);
  endfunction

endpackage

// File: rtl/enemy_ai_lfsr16.sv
// Seeded 16-bit Galois LFSR; exposes only the low nibble used for jump rolls.
module ai_lfsr16
  import enemy_ai_pkg::*;
#(
  parameter logic [15:0] SEED = AI_LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,
  output logic [3:0] nib
);

  logic [15:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= SEED;
    else if (adv) q <= lfsr_step(q);
  end

  assign nib = q[3:0];

endmodule

// File: rtl/enemy_ai.sv
// Per-frame opponent decision FSM driving enemy motion commands as one-cycle pulses.
module enemy_ai
  import enemy_ai_pkg::*;
#(
  parameter int unsigned NEAR_DIST     = AI_NEAR_DIST,
  parameter int unsigned REACT_FRAMES  = AI_REACT_FRAMES,
  parameter int unsigned DEFEND_FRAMES = AI_DEFEND_FRAMES,
  parameter int unsigned ATK_COOLDOWN  = AI_ATK_COOLDOWN,
  parameter logic [15:0] LFSR_SEED     = AI_LFSR_SEED
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame,
  input  logic                  enable,
  input  logic signed [X_W-1:0] player_x,
  input  logic                  player_isJ,
  input  logic                  player_atk,
  input  logic signed [X_W-1:0] enemy_x,
  input  logic                  enemy_isJ,
  output logic                  right,
  output logic                  left,
  output logic                  jump,
  output logic                  squat,
  output logic                  defend,
  output logic                  attack,
  output logic [2:0]            state
);

  ai_state_e              st_q, st_d, dec_state;
  ai_cmd_t                cmd_q, cmd_d, dec_cmd;
  logic [CNT_W-1:0]       react_q, react_d, guard_q, guard_d, cd_q, cd_d;
  logic [3:0]             rnd;
  logic signed [DX_W-1:0] dx;
  logic [DX_W-1:0]        ad;
  logic                   near, dx_pos, dx_neg, roll_jump;

  ai_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (frame & enable),
    .nib   (rnd)
  );

  // Sign-extend before subtracting so the full +/-2047 range fits.
  assign dx     = {enemy_x[X_W-1], enemy_x} - {player_x[X_W-1], player_x};
  assign ad     = dx[DX_W-1] ? DX_W'(-dx) : DX_W'(dx);
  assign near   = (ad <= DX_W'(NEAR_DIST));
  assign dx_neg = dx[DX_W-1];
  assign dx_pos = !dx[DX_W-1] && (dx != '0);
  assign roll_jump = (rnd == 4'd0) && !enemy_isJ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= AI_IDLE;
      cmd_q   <= '0;
      react_q <= CNT_W'(REACT_FRAMES);
      guard_q <= '0;
      cd_q    <= '0;
    end else begin
      st_q    <= st_d;
      cmd_q   <= cmd_d;
      react_q <= react_d;
      guard_q <= guard_d;
      cd_q    <= cd_d;
    end
  end

  always_comb begin
    dec_state = AI_APPROACH;
    dec_cmd   = '0;
    if (player_atk && near) begin
      dec_state      = AI_GUARD;
      dec_cmd.defend = 1'b1;
    end else if (near && cd_q == '0) begin
      dec_state      = AI_ATTACK;
      dec_cmd.attack = 1'b1;
    end else if (near) begin
      dec_state     = AI_RETREAT;
      dec_cmd.right = dx_pos;
      dec_cmd.left  = dx_neg;
      dec_cmd.jump  = roll_jump;
      dec_cmd.squat = player_isJ && !enemy_isJ && !roll_jump;
    end else begin
      dec_cmd.left  = dx_pos;
      dec_cmd.right = dx_neg;
      dec_cmd.jump  = roll_jump;
    end
  end

  always_comb begin
    st_d    = st_q;
    cmd_d   = '0;
    react_d = react_q;
    guard_d = guard_q;
    cd_d    = cd_q;
    if (!enable) begin
      st_d    = AI_IDLE;
      react_d = CNT_W'(REACT_FRAMES);
      guard_d = '0;
      if (frame && cd_q != '0) cd_d = cd_q - CNT_ONE;
    end else if (frame) begin
      if (cd_q != '0) cd_d = cd_q - CNT_ONE;
      case (st_q)
        AI_IDLE: begin
          if (react_q != '0) react_d = react_q - CNT_ONE;
          else begin
            st_d  = dec_state;
            cmd_d = dec_cmd;
          end
        end
        AI_GUARD: begin
          if (guard_q != '0) begin
            cmd_d.defend = 1'b1;
            guard_d      = guard_q - CNT_ONE;
          end
          if (guard_q <= CNT_ONE) begin
            st_d    = AI_IDLE;
            react_d = CNT_W'(REACT_FRAMES);
          end
        end
        default: begin
          st_d  = dec_state;
          cmd_d = dec_cmd;
        end
      endcase
      // Entry frame already accounts for the first of the defend frames.
      if (cmd_d.defend && st_q != AI_GUARD) guard_d = CNT_W'(DEFEND_FRAMES - 1);
      if (cmd_d.attack) cd_d = CNT_W'(ATK_COOLDOWN);
    end
  end

  assign right  = cmd_q.right;
  assign left   = cmd_q.left;
  assign jump   = cmd_q.jump;
  assign squat  = cmd_q.squat;
  assign defend = cmd_q.defend;
  assign attack = cmd_q.attack;
  assign state  = st_q;

endmodule

// File: tb/tb_enemy_ai.sv
// Scoreboard bench for enemy_ai: a behavioural model queues expected pulses per frame.
module tb_enemy_ai;

  logic clk = 1'b0;
  logic rst_n, frame, enable, player_isJ, player_atk, enemy_isJ;
  logic signed [10:0] player_x, enemy_x;
  logic right, left, jump, squat, defend, attack;
  logic [2:0] state;

  enemy_ai #(
    .NEAR_DIST     (48),
    .REACT_FRAMES  (3),
    .DEFEND_FRAMES (8),
    .ATK_COOLDOWN  (12),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame      (frame),
    .enable     (enable),
    .player_x   (player_x),
    .player_isJ (player_isJ),
    .player_atk (player_atk),
    .enemy_x    (enemy_x),
    .enemy_isJ  (enemy_isJ),
    .right      (right),
    .left       (left),
    .jump       (jump),
    .squat      (squat),
    .defend     (defend),
    .attack     (attack),
    .state      (state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int m_state, m_react, m_cd, m_guard, m_jumps;
  logic [15:0] m_lfsr;
  logic [8:0] sb_q[$];

  int cnt_l, cnt_r, cnt_j, cnt_att, cnt_def, frame_idx, last_att, att_gap;

  task automatic check_eq(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] obs();
    return {state, right, left, jump, squat, defend, attack};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_react = 3;
    m_cd    = 0;
    m_guard = 0;
    m_lfsr  = 16'hACE1;
    m_jumps = 0;
    sb_q.delete();
  endtask

  task automatic clear_counts();
    cnt_l = 0; cnt_r = 0; cnt_j = 0; cnt_att = 0; cnt_def = 0;
    frame_idx = 0; last_att = -1; att_gap = -1;
  endtask

  task automatic model_frame();
    int dxi, adi, nst;
    bit near, r, l, j, s, d, a, dec;
    r = 0; l = 0; j = 0; s = 0; d = 0; a = 0; dec = 0;
    nst  = m_state;
    dxi  = int'(enemy_x) - int'(player_x);
    adi  = (dxi < 0) ? -dxi : dxi;
    near = (adi <= 48);
    if (m_state == 0 && m_react > 0) m_react--;
    else if (m_state == 3) begin
      if (m_guard > 0) begin d = 1; m_guard--; end
      if (m_guard == 0) begin nst = 0; m_react = 3; end
    end else dec = 1;
    if (dec) begin
      if (player_atk && near) begin
        nst = 3; d = 1;
        m_guard = 8 - 1;  // entry frame is the first of eight defend frames
      end else if (near && m_cd == 0) begin
        nst = 4; a = 1;
      end else begin
        nst = near ? 2 : 1;
        if (near) begin r = (dxi > 0); l = (dxi < 0); end
        else      begin l = (dxi > 0); r = (dxi < 0); end
        j = (m_lfsr[3:0] == 4'd0) && !enemy_isJ;
        s = near && player_isJ && !enemy_isJ && !j;
      end
    end
    if (a) m_cd = 12;
    else if (m_cd > 0) m_cd--;
    m_lfsr  = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    m_jumps += int'(j);
    m_state = nst;
    sb_q.push_back({3'(nst), r, l, j, s, d, a});
  endtask

  task automatic run_frame();
    logic [8:0] exp, got;
    @(negedge clk);
    frame = 1'b1;
    model_frame();
    @(negedge clk);
    frame = 1'b0;
    got = obs();
    if (sb_q.size() == 0) check_eq("sb_empty", 1, 0);
    else begin
      exp = sb_q.pop_front();
      check_eq("frame", int'(got), int'(exp));
    end
    frame_idx++;
    cnt_r   += int'(right);
    cnt_l   += int'(left);
    cnt_j   += int'(jump);
    cnt_def += int'(defend);
    if (attack) begin
      cnt_att++;
      if (last_att >= 0) att_gap = frame_idx - last_att;
      last_att = frame_idx;
    end
    @(negedge clk);
    got = obs();
    check_eq("quiet", int'(got[5:0]), 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    frame = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] exp_v;
    rst_n = 1'b0; frame = 1'b0; enable = 1'b1;
    player_isJ = 1'b0; player_atk = 1'b0; enemy_isJ = 1'b0;
    player_x = 11'sd100; enemy_x = 11'sd500;

    do_reset();
    check_eq("rst_outputs", int'(obs()), 0);
    check_eq("rst_lfsr", int'(dut.u_lfsr.q), 16'hACE1);

    // Spawn wait then approach leftwards
    clear_counts();
    repeat (3) run_frame();
    check_eq("spawn_silent", cnt_l + cnt_r + cnt_att + cnt_def + cnt_j, 0);
    repeat (5) run_frame();
    check_eq("spawn_left", cnt_l, 5);
    check_eq("spawn_right", cnt_r, 0);
    check_eq("spawn_state", int'(state), 1);

    // dx == 0: attack, then retreat frames without a direction
    player_x = 11'sd500;
    clear_counts();
    repeat (4) run_frame();
    check_eq("dx0_attack", cnt_att, 1);
    check_eq("dx0_nodir", cnt_l + cnt_r, 0);

    // Extreme coordinates: ad = 2047 with no wrap
    do_reset();
    player_x = -11'sd1024; enemy_x = 11'sd1023;
    repeat (3) run_frame();
    clear_counts();
    repeat (3) run_frame();
    check_eq("wide_left", cnt_l, 3);
    player_x = 11'sd1023; enemy_x = -11'sd1024;
    clear_counts();
    repeat (3) run_frame();
    check_eq("wide_right", cnt_r, 3);

    // Attack and cooldown period
    do_reset();
    player_x = 11'sd460; enemy_x = 11'sd500;
    repeat (3) run_frame();
    clear_counts();
    repeat (27) run_frame();
    check_eq("cd_attacks", cnt_att, 3);
    check_eq("cd_period", att_gap, 13);
    check_eq("cd_retreats", cnt_r, 24);

    // Guard: eight defend frames then three silent IDLE frames
    do_reset();
    repeat (3) run_frame();
    clear_counts();
    player_atk = 1'b1;
    run_frame();
    player_atk = 1'b0;
    repeat (7) run_frame();
    check_eq("guard_defends", cnt_def, 8);
    check_eq("guard_no_attack", cnt_att, 0);
    clear_counts();
    repeat (3) run_frame();
    check_eq("guard_idle_silent", cnt_l + cnt_r + cnt_att + cnt_def + cnt_j, 0);
    run_frame();
    check_eq("guard_then_attack", cnt_att, 1);

    // Random jumps
    do_reset();
    player_x = 11'sd100; enemy_x = 11'sd500;
    repeat (3) run_frame();
    clear_counts();
    m_jumps = 0;
    repeat (256) run_frame();
    check_eq("jumps_ground", cnt_j, m_jumps);
    enemy_isJ = 1'b1;
    clear_counts();
    repeat (256) run_frame();
    check_eq("jumps_airborne", cnt_j, 0);
    enemy_isJ = 1'b0;

    // Enable low while guarding
    do_reset();
    player_x = 11'sd460; enemy_x = 11'sd500;
    repeat (3) run_frame();
    player_atk = 1'b1;
    run_frame();
    player_atk = 1'b0;
    repeat (2) run_frame();
    check_eq("guard_before_dis", int'(state), 3);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check_eq("disable_idle", int'(obs()), 0);
    enable = 1'b1;
    m_state = 0; m_react = 3; m_guard = 0;
    clear_counts();
    repeat (4) run_frame();
    check_eq("reenable_attack", cnt_att, 1);
    run_frame();

    // Async reset while a retreat pulse is live
    @(negedge clk);
    frame = 1'b1;
    model_frame();
    @(posedge clk);
    #2;
    frame = 1'b0;
    exp_v = sb_q.pop_front();
    check_eq("pre_reset_pulse", int'(obs()), int'(exp_v));
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_outputs", int'(obs()), 0);
    check_eq("async_rst_lfsr", int'(dut.u_lfsr.q), 16'hACE1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
